// File: rtl/adc_stereo_deserializer_if.sv
// Serial ADC input (ADCDAT/ADCLRCK) and parallel stereo output bundle.
// master = deserializer side, slave = codec/consumer side.
interface adc_stereo_deserializer_if #(
  parameter int SAMPLE_W = 16
);
  logic                    ADCDAT;
  logic                    ADCLRCK;
  logic [SAMPLE_W-1:0]     LEFT_SAMPLE;
  logic [SAMPLE_W-1:0]     RIGHT_SAMPLE;
  logic [2*SAMPLE_W-1:0]   ADCDAT_PAR;
  logic                    SAMPLE_VALID;
  logic                    FRAME_ERR;

  modport master (
    input  ADCDAT, ADCLRCK,
    output LEFT_SAMPLE, RIGHT_SAMPLE, ADCDAT_PAR, SAMPLE_VALID, FRAME_ERR
  );

  modport slave (
    output ADCDAT, ADCLRCK,
    input  LEFT_SAMPLE, RIGHT_SAMPLE, ADCDAT_PAR, SAMPLE_VALID, FRAME_ERR
  );
endinterface

// File: rtl/adc_stereo_deserializer.sv
// Serial LJ/I2S ADC stream to one parallel stereo pair per LRCK frame; ADC_DESER_FRAME_ERR_EN enables short-slot discard.
// Latency: SAMPLE_VALID one BCLK after the right-channel LSB capture edge.
// No backpressure: free-running in the BCLK domain, the consumer must take each strobe.
module adc_stereo_deserializer #(
  parameter int SAMPLE_W = 16,
  parameter bit I2S_MODE = 1'b0,
  parameter bit LEFT_LVL = 1'b1
) (
  input logic                       BCLK,
  input logic                       RESET,
  adc_stereo_deserializer_if.master bus
);
  localparam int CW = $clog2(SAMPLE_W + 1);
  localparam logic [CW-1:0] FULL      = CW'(SAMPLE_W);
  localparam logic [CW-1:0] START_CNT = I2S_MODE ? '0 : CW'(1);

  typedef enum logic [2:0] {WAIT_SYNC, SHIFT_L, IDLE_L, SHIFT_R, IDLE_R} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n, fill;
  logic [SAMPLE_W-1:0] left_sr, left_sr_n, right_sr, right_sr_n;
  logic [SAMPLE_W-1:0] left_hold, left_hold_n;
  logic [SAMPLE_W-1:0] left_shift, right_shift, start_sr;
  logic                lrck_q, done, done_n;
  logic                slot_start, left_start, right_start, short_slot;

  assign slot_start  = bus.ADCLRCK != lrck_q;
  assign left_start  = slot_start && (bus.ADCLRCK == LEFT_LVL);
  assign right_start = slot_start && (bus.ADCLRCK != LEFT_LVL);
  assign short_slot  = slot_start && (state == SHIFT_L || state == SHIFT_R);

  assign fill        = FULL - cnt;
  assign left_shift  = {left_sr[SAMPLE_W-2:0], bus.ADCDAT};
  assign right_shift = {right_sr[SAMPLE_W-2:0], bus.ADCDAT};
  // In LJ the slot-start cycle already carries the MSB; I2S skips it.
  assign start_sr    = I2S_MODE ? '0 : {{(SAMPLE_W-1){1'b0}}, bus.ADCDAT};

`ifdef ADC_DESER_FRAME_ERR_EN
  logic err_n;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    left_sr_n   = left_sr;
    right_sr_n  = right_sr;
    left_hold_n = left_hold;
    done_n      = 1'b0;
`ifdef ADC_DESER_FRAME_ERR_EN
    err_n       = 1'b0;
`endif
    case (state)
      SHIFT_L: if (!slot_start) begin
        left_sr_n = left_shift;
        cnt_n     = cnt + 1'b1;
        if (cnt + 1'b1 == FULL) begin
          state_n     = IDLE_L;
          left_hold_n = left_shift;
        end
      end
      SHIFT_R: if (!slot_start) begin
        right_sr_n = right_shift;
        cnt_n      = cnt + 1'b1;
        if (cnt + 1'b1 == FULL) begin
          state_n = IDLE_R;
          done_n  = 1'b1;
        end
      end
      default: ;
    endcase

    if (short_slot) begin
`ifdef ADC_DESER_FRAME_ERR_EN
      err_n = 1'b1;
`else
      // Missing LSBs become zeros and the slot counts as complete.
      if (state == SHIFT_L) begin
        left_hold_n = left_sr << fill;
      end else begin
        right_sr_n = right_sr << fill;
        done_n     = 1'b1;
      end
`endif
    end

    if (left_start) begin
      state_n   = SHIFT_L;
      cnt_n     = START_CNT;
      left_sr_n = start_sr;
    end else if (right_start && state != WAIT_SYNC) begin
      state_n    = SHIFT_R;
      cnt_n      = START_CNT;
      right_sr_n = start_sr;
`ifdef ADC_DESER_FRAME_ERR_EN
      if (short_slot) state_n = WAIT_SYNC;
`endif
    end
  end

  always_ff @(posedge BCLK) begin
    if (RESET) begin
      state            <= WAIT_SYNC;
      cnt              <= '0;
      left_sr          <= '0;
      right_sr         <= '0;
      left_hold        <= '0;
      done             <= 1'b0;
      lrck_q           <= bus.ADCLRCK;
      bus.LEFT_SAMPLE  <= '0;
      bus.RIGHT_SAMPLE <= '0;
      bus.SAMPLE_VALID <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      left_sr          <= left_sr_n;
      right_sr         <= right_sr_n;
      left_hold        <= left_hold_n;
      done             <= done_n;
      lrck_q           <= bus.ADCLRCK;
      bus.SAMPLE_VALID <= done;
      if (done) begin
        bus.LEFT_SAMPLE  <= left_hold;
        bus.RIGHT_SAMPLE <= right_sr;
      end
    end
  end

`ifdef ADC_DESER_FRAME_ERR_EN
  always_ff @(posedge BCLK) begin
    if (RESET) bus.FRAME_ERR <= 1'b0;
    else       bus.FRAME_ERR <= err_n;
  end
`else
  assign bus.FRAME_ERR = 1'b0;
`endif

  assign bus.ADCDAT_PAR = {bus.LEFT_SAMPLE, bus.RIGHT_SAMPLE};
endmodule

// File: tb/tb_adc_stereo_deserializer.sv
// Bench for adc_stereo_deserializer: three instances (LJ/16, I2S/24, LJ/16 with LEFT_LVL=0),
// expected pairs queued at stimulus time and matched by a monitor on SAMPLE_VALID.
module tb_adc_stereo_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_stereo_deserializer_if #(.SAMPLE_W(16)) b0();
  adc_stereo_deserializer_if #(.SAMPLE_W(24)) b1();
  adc_stereo_deserializer_if #(.SAMPLE_W(16)) b2();

  adc_stereo_deserializer #(.SAMPLE_W(16), .I2S_MODE(1'b0), .LEFT_LVL(1'b1))
    d0 (.BCLK(clk), .RESET(rst), .bus(b0.master));
  adc_stereo_deserializer #(.SAMPLE_W(24), .I2S_MODE(1'b1), .LEFT_LVL(1'b1))
    d1 (.BCLK(clk), .RESET(rst), .bus(b1.master));
  adc_stereo_deserializer #(.SAMPLE_W(16), .I2S_MODE(1'b0), .LEFT_LVL(1'b0))
    d2 (.BCLK(clk), .RESET(rst), .bus(b2.master));

  logic sdat[3];
  logic slrck[3];
  assign b0.ADCDAT = sdat[0];  assign b0.ADCLRCK = slrck[0];
  assign b1.ADCDAT = sdat[1];  assign b1.ADCLRCK = slrck[1];
  assign b2.ADCDAT = sdat[2];  assign b2.ADCLRCK = slrck[2];

  typedef struct {
    int          id;
    logic [63:0] par;
    logic [31:0] l;
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   err_cnt[3] = '{0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every SAMPLE_VALID must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    logic        v[3];
    logic [63:0] par[3];
    logic [31:0] l[3], r[3];
    exp_t        e;
    v[0] = b0.SAMPLE_VALID; par[0] = 64'(b0.ADCDAT_PAR); l[0] = 32'(b0.LEFT_SAMPLE); r[0] = 32'(b0.RIGHT_SAMPLE);
    v[1] = b1.SAMPLE_VALID; par[1] = 64'(b1.ADCDAT_PAR); l[1] = 32'(b1.LEFT_SAMPLE); r[1] = 32'(b1.RIGHT_SAMPLE);
    v[2] = b2.SAMPLE_VALID; par[2] = 64'(b2.ADCDAT_PAR); l[2] = 32'(b2.LEFT_SAMPLE); r[2] = 32'(b2.RIGHT_SAMPLE);
    for (int i = 0; i < 3; i++) begin
      if (v[i] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid dut%0d cyc=%0d par=%h, required no SAMPLE_VALID", i, cyc, par[i]);
        end else begin
          e = exp_q.pop_front();
          if (i !== e.id || par[i] !== e.par || l[i] !== e.l || r[i] !== e.r || cyc !== e.c) begin
            fails++;
            $display("FAIL pair dut%0d cyc=%0d L=%h R=%h PAR=%h, required dut%0d cyc=%0d L=%h R=%h PAR=%h",
                     i, cyc, l[i], r[i], par[i], e.id, e.c, e.l, e.r, e.par);
          end
        end
      end
    end
    if (b0.FRAME_ERR === 1'b1) err_cnt[0]++;
    if (b1.FRAME_ERR === 1'b1) err_cnt[1]++;
    if (b2.FRAME_ERR === 1'b1) err_cnt[2]++;
  end

  task automatic send_slot(input int id, input logic lvl, input logic [31:0] word,
                           input int w, input int len, input bit i2s);
    int pos;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      slrck[id] = lvl;
      pos = k - (i2s ? 1 : 0);
      if (pos >= 0 && pos < w) sdat[id] = word[w-1-pos];
      else                     sdat[id] = 1'($urandom);
    end
  endtask

  // Called at a negedge; drive index j of the frame lands on cycle cyc+1+j.
  task automatic send_frame(input int id, input logic llvl, input logic [31:0] l, input logic [31:0] r,
                            input int w, input int llen, input int rlen, input bit i2s,
                            input bit expect_out, input logic [31:0] el, input logic [31:0] er);
    exp_t e;
    int   base;
    base = cyc;
    if (expect_out) begin
      e.id  = id;
      e.l   = el;
      e.r   = er;
      e.par = (64'(el) << w) | 64'(er);
      e.c   = (rlen >= w + (i2s ? 1 : 0)) ? base + llen + (i2s ? 1 : 0) + w + 2 : base + llen + rlen + 3;
      exp_q.push_back(e);
    end
    send_slot(id, llvl, l, w, llen, i2s);
    send_slot(id, ~llvl, r, w, rlen, i2s);
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_valid pending=%0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sdat[i] = 1'b0;
    slrck[0] = 1'b0; slrck[1] = 1'b0; slrck[2] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({b0.ADCDAT_PAR, b0.SAMPLE_VALID, b0.FRAME_ERR} !== '0) begin
      fails++; $display("FAIL reset_dut0 par=%h v=%b e=%b, required all 0", b0.ADCDAT_PAR, b0.SAMPLE_VALID, b0.FRAME_ERR);
    end
    tests++;
    if ({b1.ADCDAT_PAR, b1.SAMPLE_VALID, b1.FRAME_ERR} !== '0) begin
      fails++; $display("FAIL reset_dut1 par=%h v=%b e=%b, required all 0", b1.ADCDAT_PAR, b1.SAMPLE_VALID, b1.FRAME_ERR);
    end
    tests++;
    if ({b2.ADCDAT_PAR, b2.SAMPLE_VALID, b2.FRAME_ERR} !== '0) begin
      fails++; $display("FAIL reset_dut2 par=%h v=%b e=%b, required all 0", b2.ADCDAT_PAR, b2.SAMPLE_VALID, b2.FRAME_ERR);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({b0.ADCDAT_PAR, b0.SAMPLE_VALID} !== '0) begin
      fails++; $display("FAIL post_reset_hold par=%h v=%b, required 0", b0.ADCDAT_PAR, b0.SAMPLE_VALID);
    end
  endtask

  task automatic test_lj_back_to_back();
    send_frame(0, 1'b1, 32'hA5C3, 32'h1234, 16, 32, 32, 1'b0, 1'b1, 32'hA5C3, 32'h1234);
    send_frame(0, 1'b1, 32'hFFFF, 32'h0001, 16, 32, 32, 1'b0, 1'b1, 32'hFFFF, 32'h0001);
    send_frame(0, 1'b1, 32'h0000, 32'h8000, 16, 32, 32, 1'b0, 1'b1, 32'h0000, 32'h8000);
    drain("lj");
    tests++;
    if (b0.ADCDAT_PAR !== 32'h00008000 || err_cnt[0] != 0) begin
      fails++; $display("FAIL lj_hold par=%h errs=%0d, required 00008000 and 0", b0.ADCDAT_PAR, err_cnt[0]);
    end
  endtask

  task automatic test_i2s24();
    send_frame(1, 1'b1, 32'h800001, 32'h7FFFFF, 24, 32, 32, 1'b1, 1'b1, 32'h800001, 32'h7FFFFF);
    send_frame(1, 1'b1, 32'h123456, 32'hABCDEF, 24, 32, 32, 1'b1, 1'b1, 32'h123456, 32'hABCDEF);
    drain("i2s");
    tests++;
    if (b1.LEFT_SAMPLE !== 24'h123456 || b1.RIGHT_SAMPLE !== 24'hABCDEF) begin
      fails++; $display("FAIL i2s_hold L=%h R=%h, required 123456 abcdef", b1.LEFT_SAMPLE, b1.RIGHT_SAMPLE);
    end
  endtask

  task automatic test_left_lvl0();
    // Tail of a right slot first: that edge must not synchronise.
    send_slot(2, 1'b1, 32'hDEAD, 16, 12, 1'b0);
    send_frame(2, 1'b0, 32'h0F0F, 32'hF00F, 16, 32, 32, 1'b0, 1'b1, 32'h0F0F, 32'hF00F);
    send_frame(2, 1'b0, 32'h1111, 32'h2222, 16, 32, 32, 1'b0, 1'b1, 32'h1111, 32'h2222);
    drain("lvl0");
    tests++;
    if (b2.ADCDAT_PAR !== 32'h11112222 || err_cnt[2] != 0) begin
      fails++; $display("FAIL lvl0_hold par=%h errs=%0d, required 11112222 and 0", b2.ADCDAT_PAR, err_cnt[2]);
    end
  endtask

  task automatic test_short_slot();
    int          e0;
    int          exp_err;
    logic [31:0] exp_mid;
    e0 = err_cnt[0];
`ifdef ADC_DESER_FRAME_ERR_EN
    send_frame(0, 1'b1, 32'h5A5A, 32'hFFFF, 16, 32, 10, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_mid = 32'h00008000;
    exp_err = e0 + 1;
`else
    send_frame(0, 1'b1, 32'h5A5A, 32'hFFFF, 16, 32, 10, 1'b0, 1'b1, 32'h5A5A, 32'hFFC0);
    exp_mid = 32'h5A5AFFC0;
    exp_err = e0;
`endif
    fork
      send_frame(0, 1'b1, 32'h3C3C, 32'hC3C3, 16, 32, 32, 1'b0, 1'b1, 32'h3C3C, 32'hC3C3);
      begin
        repeat (6) @(negedge clk);
        tests++;
        if (b0.ADCDAT_PAR !== exp_mid) begin
          fails++; $display("FAIL short_outputs par=%h, required %h", b0.ADCDAT_PAR, exp_mid);
        end
        tests++;
        if (err_cnt[0] != exp_err) begin
          fails++; $display("FAIL short_frame_err pulses=%0d, required %0d", err_cnt[0], exp_err);
        end
      end
    join
    drain("short");
    tests++;
    if (b0.ADCDAT_PAR !== 32'h3C3CC3C3 || err_cnt[0] != exp_err) begin
      fails++; $display("FAIL short_recover par=%h errs=%0d, required 3c3cc3c3 and %0d", b0.ADCDAT_PAR, err_cnt[0], exp_err);
    end
  endtask

  task automatic test_reset_midframe();
    send_slot(0, 1'b1, 32'hBEEF, 16, 7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({b0.ADCDAT_PAR, b0.SAMPLE_VALID, b0.FRAME_ERR} !== '0) begin
      fails++; $display("FAIL midreset_clear par=%h v=%b, required all 0", b0.ADCDAT_PAR, b0.SAMPLE_VALID);
    end
    send_slot(0, 1'b1, 32'h0, 16, 20, 1'b0);
    send_slot(0, 1'b0, 32'h7777, 16, 32, 1'b0);
    tests++;
    if (b0.ADCDAT_PAR !== 32'h0) begin
      fails++; $display("FAIL midreset_broken_frame par=%h, required 0", b0.ADCDAT_PAR);
    end
    send_frame(0, 1'b1, 32'h1357, 32'h2468, 16, 32, 32, 1'b0, 1'b1, 32'h1357, 32'h2468);
    drain("midreset");
    tests++;
    if (b0.ADCDAT_PAR !== 32'h13572468) begin
      fails++; $display("FAIL midreset_resume par=%h, required 13572468", b0.ADCDAT_PAR);
    end
  endtask

  initial begin
    test_reset();
    test_lj_back_to_back();
    test_i2s24();
    test_left_lvl0();
    test_short_slot();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
